// File: rtl/sd_arb_pkg.sv
// Shared types for the SD port arbiter: FSM states, latched operation and
// client index encoding.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int CLIENT_W = 1;
  typedef logic [CLIENT_W-1:0] client_t;

  localparam client_t CLIENT_A = 1'b0;
  localparam client_t CLIENT_B = 1'b1;

endpackage

// File: rtl/sd_arbiter_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sd_arbiter.sv
// Shares the MiST I/O controller's SD block port between two clients:
// round-robin grant, rd/wr -> ack handshake, buffer routing, timeout.
module sd_arbiter
  import sd_arb_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [31:0] lba_a,
  input  logic [31:0] lba_b,
  input  logic        rd_a,
  input  logic        rd_b,
  input  logic        wr_a,
  input  logic        wr_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic        done_a,
  output logic        done_b,
  output logic        err_a,
  output logic        err_b,
  output logic        buff_wr_a,
  output logic        buff_wr_b,
  input  logic [7:0]  buff_din_a,
  input  logic [7:0]  buff_din_b,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din
);

  state_t      state, state_nxt;
  op_t         op, op_nxt;
  client_t     grant, grant_nxt;
  client_t     last, last_nxt;
  client_t     win;
  logic [31:0] lba_nxt;
  logic [23:0] tmo_cnt, tmo_nxt;
  logic [1:0]  err_q, err_nxt;
  logic        ack_s, ack_s_d;
  logic        req_a, req_b;
  logic        ack_rise, ack_fall, timed_out, active;

  sync2 u_ack_sync (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .d     (sd_ack),
    .q     (ack_s)
  );

  assign req_a     = rd_a | wr_a;
  assign req_b     = rd_b | wr_b;
  assign ack_rise  = ack_s & ~ack_s_d;
  assign ack_fall  = ~ack_s & ack_s_d;
  assign timed_out = (TIMEOUT != 24'd0) && (tmo_cnt == TIMEOUT - 24'd1);

  // On contention the client that was not served last takes the grant.
  assign win = (req_a && (!req_b || last == CLIENT_B)) ? CLIENT_A : CLIENT_B;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      op      <= OP_RD;
      grant   <= CLIENT_A;
      last    <= CLIENT_B;
      sd_lba  <= 32'd0;
      tmo_cnt <= 24'd0;
      err_q   <= 2'b00;
      ack_s_d <= 1'b0;
    end else begin
      state   <= state_nxt;
      op      <= op_nxt;
      grant   <= grant_nxt;
      last    <= last_nxt;
      sd_lba  <= lba_nxt;
      tmo_cnt <= tmo_nxt;
      err_q   <= err_nxt;
      ack_s_d <= ack_s;
    end
  end

  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    grant_nxt = grant;
    last_nxt  = last;
    lba_nxt   = sd_lba;
    tmo_nxt   = tmo_cnt;
    err_nxt   = 2'b00;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          grant_nxt = win;
          last_nxt  = win;
          tmo_nxt   = 24'd0;
          state_nxt = REQ;
          if (win == CLIENT_B) begin
            lba_nxt = lba_b;
            op_nxt  = rd_b ? OP_RD : OP_WR;
          end else begin
            lba_nxt = lba_a;
            op_nxt  = rd_a ? OP_RD : OP_WR;
          end
        end
      end
      REQ: begin
        if (ack_rise) begin
          state_nxt = XFER;
        end else if (timed_out) begin
          state_nxt = IDLE;
          if (grant == CLIENT_B) err_nxt = 2'b10;
          else                   err_nxt = 2'b01;
        end else if (tmo_cnt != 24'hFF_FFFF) begin
          tmo_nxt = tmo_cnt + 24'd1;
        end
      end
      XFER: begin
        if (ack_fall) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign active      = (state == REQ) || (state == XFER);
  assign sd_rd       = active && (op == OP_RD);
  assign sd_wr       = active && (op == OP_WR);
  assign ack_a       = (state == XFER) && (grant == CLIENT_A);
  assign ack_b       = (state == XFER) && (grant == CLIENT_B);
  assign done_a      = (state == DONE) && (grant == CLIENT_A);
  assign done_b      = (state == DONE) && (grant == CLIENT_B);
  assign err_a       = err_q[0];
  assign err_b       = err_q[1];
  assign buff_wr_a   = sd_buff_wr & ack_a;
  assign buff_wr_b   = sd_buff_wr & ack_b;
  assign sd_buff_din = ((state != IDLE) && (grant == CLIENT_B)) ? buff_din_b : buff_din_a;

endmodule

// File: tb/tb_sd_arbiter.sv
// Scoreboard bench for sd_arbiter: directed client/host scenarios push expected
// grant/done/err events, a negedge monitor pops and compares them.
module tb_sd_arbiter;

  localparam logic [23:0] TMO = 24'd100;
  localparam logic [1:0] EV_GRANT = 2'd0, EV_DONE = 2'd1, EV_ERR = 2'd2;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] lba_a = '0, lba_b = '0;
  logic        rd_a = 0, rd_b = 0, wr_a = 0, wr_b = 0;
  logic        ack_a, ack_b, done_a, done_b, err_a, err_b, buff_wr_a, buff_wr_b;
  logic [7:0]  buff_din_a = '0, buff_din_b = '0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack = 0, sd_buff_wr = 0;
  logic [7:0]  sd_buff_din;

  always #5 clk_sys = ~clk_sys;

  sd_arbiter #(.TIMEOUT(TMO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .lba_a(lba_a), .lba_b(lba_b), .rd_a(rd_a), .rd_b(rd_b), .wr_a(wr_a), .wr_b(wr_b),
    .ack_a(ack_a), .ack_b(ack_b), .done_a(done_a), .done_b(done_b),
    .err_a(err_a), .err_b(err_b), .buff_wr_a(buff_wr_a), .buff_wr_b(buff_wr_b),
    .buff_din_a(buff_din_a), .buff_din_b(buff_din_b),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic        client;
    logic [31:0] lba;
    logic        is_wr;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  bw_a = 0, bw_b = 0;
  int  din_bad = 0, din_samples = 0;
  logic din_watch = 1'b0;
  logic req_prev  = 1'b0;

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push_ev(logic [1:0] kind, logic client, logic [31:0] lba, logic is_wr);
    ev_t e;
    e.kind = kind; e.client = client; e.lba = lba; e.is_wr = is_wr;
    exp_q.push_back(e);
  endfunction

  function automatic void expect_event(logic [1:0] kind, logic client, logic [31:0] lba,
                                       logic rd, logic wr);
    ev_t e;
    if (exp_q.size() == 0) begin
      checkOutput("unexpected event kind", 32'(kind), 32'hFF);
      return;
    end
    e = exp_q.pop_front();
    checkOutput("event kind", 32'(kind), 32'(e.kind));
    if (kind == EV_GRANT) begin
      checkOutput("grant sd_lba", lba, e.lba);
      checkOutput("grant sd_rd", 32'(rd), 32'(!e.is_wr));
      checkOutput("grant sd_wr", 32'(wr), 32'(e.is_wr));
    end else begin
      checkOutput("event client", 32'(client), 32'(e.client));
      checkOutput("rd/wr low at end", {30'd0, rd, wr}, 32'd0);
    end
  endfunction

  // Monitor: every grant, completion and timeout the DUT presents is scored.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if ((sd_rd || sd_wr) && !req_prev) expect_event(EV_GRANT, 1'b0, sd_lba, sd_rd, sd_wr);
      if (done_a) expect_event(EV_DONE, 1'b0, 32'd0, sd_rd, sd_wr);
      if (done_b) expect_event(EV_DONE, 1'b1, 32'd0, sd_rd, sd_wr);
      if (err_a)  expect_event(EV_ERR,  1'b0, 32'd0, sd_rd, sd_wr);
      if (err_b)  expect_event(EV_ERR,  1'b1, 32'd0, sd_rd, sd_wr);
    end
    req_prev <= sd_rd | sd_wr;
  end

  always @(posedge clk_sys) begin
    if (buff_wr_a) bw_a++;
    if (buff_wr_b) bw_b++;
  end

  always @(negedge clk_sys) begin
    if (din_watch) begin
      din_samples++;
      if (sd_buff_din !== 8'hA5) din_bad++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyReset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic wait_grant(output int lat);
    lat = 0;
    while (!(sd_rd || sd_wr) && lat < 200) begin
      @(negedge clk_sys);
      lat++;
    end
    checkOutput("grant seen", 32'(sd_rd | sd_wr), 32'd1);
  endtask

  // Host side of the I/O controller: ack after a delay, stream bytes, release ack.
  task automatic host_serve(input int delay, input int nbytes, output int ack_lat, output int done_lat);
    repeat (delay) @(negedge clk_sys);
    sd_ack  = 1'b1;
    ack_lat = 0;
    while (!(ack_a || ack_b) && ack_lat < 50) begin
      @(negedge clk_sys);
      ack_lat++;
    end
    for (int i = 0; i < nbytes; i++) begin
      sd_buff_wr = 1'b1;
      @(negedge clk_sys);
      sd_buff_wr = 1'b0;
      @(negedge clk_sys);
    end
    sd_ack   = 1'b0;
    done_lat = 0;
    while (!(done_a || done_b) && done_lat < 50) begin
      @(negedge clk_sys);
      done_lat++;
    end
  endtask

  task automatic applyStimulus(input int test_id);
    int lat, al, dl, base_a, base_b, cnt;
    case (test_id)
      1: begin
        lba_a = 32'h0000_1234;
        push_ev(EV_GRANT, 1'b0, 32'h0000_1234, 1'b0);
        push_ev(EV_DONE, 1'b0, 32'd0, 1'b0);
        base_a = bw_a; base_b = bw_b;
        rd_a = 1'b1;
        wait_grant(lat);
        checkOutput("single grant latency", lat, 1);
        host_serve(10, 512, al, dl);
        rd_a = 1'b0;
        checkOutput("single ack latency", al, 3);
        checkOutput("single done latency", dl, 3);
        checkOutput("single buff_wr_a count", bw_a - base_a, 512);
        checkOutput("single buff_wr_b count", bw_b - base_b, 0);
        @(negedge clk_sys);
        checkOutput("done_a one pulse", 32'(done_a), 32'd0);
      end
      2: begin
        applyReset();
        lba_a = 32'hA1A1_0001;
        lba_b = 32'hB2B2_0002;
        push_ev(EV_GRANT, 1'b0, 32'hA1A1_0001, 1'b0);
        push_ev(EV_DONE, 1'b0, 32'd0, 1'b0);
        push_ev(EV_GRANT, 1'b1, 32'hB2B2_0002, 1'b1);
        push_ev(EV_DONE, 1'b1, 32'd0, 1'b0);
        rd_a = 1'b1; wr_b = 1'b1;
        wait_grant(lat);
        checkOutput("contention first grant latency", lat, 1);
        host_serve(3, 4, al, dl);
        rd_a = 1'b0;
        wait_grant(lat);
        checkOutput("loser grant latency", lat, 2);
        host_serve(3, 4, al, dl);
        wr_b = 1'b0;
        @(negedge clk_sys);
        for (int k = 0; k < 3; k++) begin
          push_ev(EV_GRANT, k[0], k[0] ? 32'hB2B2_0002 : 32'hA1A1_0001, k[0]);
          push_ev(EV_DONE, k[0], 32'd0, 1'b0);
        end
        rd_a = 1'b1; wr_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
          wait_grant(lat);
          checkOutput("alternating grant latency", lat, (k == 0) ? 1 : 2);
          host_serve(2, 2, al, dl);
          if (k == 2) begin
            rd_a = 1'b0; wr_b = 1'b0;
          end
        end
        @(negedge clk_sys);
      end
      3: begin
        applyReset();
        lba_b = 32'h0000_0055;
        push_ev(EV_GRANT, 1'b1, 32'h0000_0055, 1'b1);
        push_ev(EV_ERR, 1'b1, 32'd0, 1'b0);
        wr_b = 1'b1;
        wait_grant(lat);
        cnt = 0;
        while (sd_wr && cnt < 300) begin
          cnt++;
          @(negedge clk_sys);
        end
        checkOutput("timeout sd_wr high cycles", cnt, 100);
        checkOutput("err_b pulse", 32'(err_b), 32'd1);
        wr_b = 1'b0;
        @(negedge clk_sys);
        checkOutput("err_b single pulse", 32'(err_b), 32'd0);
        checkOutput("sd_wr low after timeout", 32'(sd_wr), 32'd0);
      end
      4: begin
        lba_a = 32'h0000_0077;
        push_ev(EV_GRANT, 1'b0, 32'h0000_0077, 1'b0);
        push_ev(EV_DONE, 1'b0, 32'd0, 1'b0);
        rd_a = 1'b1; wr_a = 1'b1;
        wait_grant(lat);
        checkOutput("rd wins sd_wr", 32'(sd_wr), 32'd0);
        host_serve(1, 1, al, dl);
        rd_a = 1'b0; wr_a = 1'b0;
        @(negedge clk_sys);
      end
      5: begin
        lba_a = 32'h0000_0099;
        push_ev(EV_GRANT, 1'b0, 32'h0000_0099, 1'b0);
        rd_a = 1'b1;
        wait_grant(lat);
        sd_ack = 1'b1;
        cnt = 0;
        while (!ack_a && cnt < 50) begin
          @(negedge clk_sys);
          cnt++;
        end
        checkOutput("ack_a before reset", 32'(ack_a), 32'd1);
        lba_b = 32'h0000_BEEF;
        rd_b = 1'b1;
        buff_din_b = 8'hA5;
        buff_din_a = 8'h00;
        sd_buff_wr = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async reset outputs",
                    {22'd0, sd_rd, sd_wr, ack_a, ack_b, done_a, done_b, err_a, err_b, buff_wr_a, buff_wr_b},
                    32'd0);
        checkOutput("async reset sd_lba", sd_lba, 32'd0);
        sd_buff_wr = 1'b0;
        sd_ack = 1'b0;
        rd_a = 1'b0;
        push_ev(EV_GRANT, 1'b1, 32'h0000_BEEF, 1'b0);
        push_ev(EV_DONE, 1'b1, 32'd0, 1'b0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        base_a = bw_a; base_b = bw_b;
        wait_grant(lat);
        checkOutput("grant after reset latency", lat, 1);
        din_watch = 1'b1;
        host_serve(2, 8, al, dl);
        din_watch = 1'b0;
        rd_b = 1'b0;
        checkOutput("sd_buff_din bad samples", din_bad, 0);
        checkOutput("sd_buff_din sampled", 32'(din_samples > 10), 32'd1);
        checkOutput("b transfer buff_wr_b count", bw_b - base_b, 8);
        checkOutput("b transfer buff_wr_a count", bw_a - base_a, 0);
        @(negedge clk_sys);
      end
      default: ;
    endcase
  endtask

  initial begin
    sd_buff_wr = 1'b1;
    #12;
    checkOutput("reset outputs",
                {22'd0, sd_rd, sd_wr, ack_a, ack_b, done_a, done_b, err_a, err_b, buff_wr_a, buff_wr_b},
                32'd0);
    checkOutput("reset sd_lba", sd_lba, 32'd0);
    sd_buff_wr = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    for (int t = 1; t <= 5; t++) begin
      $display("[TB] scenario %0d", t);
      applyStimulus(t);
    end
    repeat (3) @(negedge clk_sys);
    checkOutput("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
